nes_uart: RTL and testbench
===========================

NES_UART -- requirements
Module: nes_uart

Interface
REQ-001 Parameter CLK_HZ, 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, serial bit rate; DIV = CLK_HZ/BAUD (integer division, 217 at defaults).
REQ-003 clock  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sel  in  1  chip select from the external address decoder.
REQ-006 addr  in  2  register index: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-007 we  in  1  CPU write strobe, one cycle per access.
REQ-008 rd  in  1  CPU read strobe, one cycle per access.
REQ-009 din  in  8  CPU write data.
REQ-010 dout  out  8  read data.
REQ-011 irq  out  1  interrupt request, active high, level.
REQ-012 rx  in  1  serial input, asynchronous, idle high.
REQ-013 tx  out  1  serial output, idle high.

Function
REQ-014 dout SHALL be combinational: DATA reads rx_buf; STATUS reads {3'b0, tx_active, frame_err, overrun, tx_full, rx_ready}; CTRL reads {7'b0, rx_ie}; reserved reads 8'hFF.
REQ-015 Side effects SHALL occur only on edges where sel=1 and the strobe is 1; we and rd SHALL NOT both be 1 (if both are, we wins, rd side effect is ignored).
REQ-016 DATA write with tx_full=0 SHALL load din into the holding register and set tx_full; with tx_full=1 the write SHALL be dropped.
REQ-017 TX FSM states IDLE, START, DATA, STOP; in IDLE with tx_full=1 it SHALL move holding to the shift register, clear tx_full, set tx_active and enter START on the next edge.
REQ-018 Each TX state SHALL hold tx for exactly DIV clocks: START drives 0, DATA drives 8 bits LSB first, STOP drives 1; after STOP, IDLE, tx_active clear; a pending holding byte SHALL start with no extra idle bit time.
REQ-019 rx SHALL pass a 2-flop synchronizer; RX FSM states IDLE, START, DATA, STOP.
REQ-020 IDLE->START on synchronized falling edge; START samples at DIV/2 clocks, returns to IDLE if line is 1 (glitch), else proceeds; DATA and STOP sample every DIV clocks thereafter.
REQ-021 At STOP sample: if line is 0, set frame_err and discard byte; else write rx_buf, set rx_ready; if rx_ready was already 1 and not cleared on the same edge, also set overrun (new byte still overwrites rx_buf).
REQ-022 DATA read SHALL clear rx_ready; if a byte completes on the same edge, rx_ready SHALL remain 1, rx_buf takes the new byte, overrun not set.
REQ-023 STATUS read SHALL clear overrun and frame_err; a same-edge set SHALL win.
REQ-024 CTRL write SHALL load rx_ie from din[0].
REQ-025 irq SHALL equal rx_ie AND rx_ready, registered-state derived, no extra latency.
REQ-026 Baud counters SHALL be wide enough for DIV-1 and wrap to 0 at each bit boundary.

Reset
REQ-027 reset SHALL immediately force: tx=1, dout's sources cleared (rx_buf=0, all flags 0, rx_ie=0), irq=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL abort both frames with no partial byte stored; after release, RX waits for a fresh falling edge.

Verification
REQ-029 Write DATA=8'hA5 at t0 -> tx low for 217 clocks, then 1,0,1,0,0,1,0,1 each 217 clocks, then high; tx_active clears 2170 clocks after frame start.
REQ-030 Write 8'h01 then 8'h02 back-to-back, third write 8'h03 while tx_full=1 -> exactly two frames contiguous (01 then 02), 8'h03 never sent.
REQ-031 Drive serial 8'h3C on rx with rx_ie=1 -> rx_ready=1, irq=1, DATA read returns 8'h3C, next cycle rx_ready=0, irq=0.
REQ-032 Send two bytes 8'h11, 8'h22 without reading -> STATUS reads 8'h05 and DATA reads 8'h22; STATUS read afterwards returns overrun=0.
REQ-033 Drive frame with stop bit 0 -> frame_err=1, rx_ready unchanged; rx pulse low 50 clocks -> no flag changes.
REQ-034 Assert reset during TX bit 4 -> tx=1 same cycle, STATUS=8'h00; new write after release sends a complete frame.

Source files
------------

// File: rtl/nes_uart_if.sv
// CPU-side register bus of the NES UART.
// The CPU drives the master side; the UART implements the slave side.
interface nes_uart_if;
    logic       sel;
    logic [1:0] addr;
    logic       we;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output sel, addr, we, rd, din,
        input  dout, irq
    );

    modport slave (
        input  sel, addr, we, rd, din,
        output dout, irq
    );
endinterface

// File: rtl/nes_uart.sv
// 8N1 UART with a DATA/STATUS/CTRL register window.
// TX has one holding byte; RX has one buffer byte with overrun and framing flags.
module nes_uart #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200
) (
    input  logic        clock,
    input  logic        reset,
    nes_uart_if.slave   bus,
    input  logic        rx,
    output logic        tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic wr, rdv, wr_data, wr_ctrl, rd_data, rd_stat;
    assign wr      = bus.sel & bus.we;
    assign rdv     = bus.sel & bus.rd & ~bus.we;
    assign wr_data = wr  && (bus.addr == 2'd0);
    assign wr_ctrl = wr  && (bus.addr == 2'd2);
    assign rd_data = rdv && (bus.addr == 2'd0);
    assign rd_stat = rdv && (bus.addr == 2'd1);

    state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift, tx_hold;
    logic tx_full, tx_tick, tx_load, tx_active;

    assign tx_tick   = (tx_cnt == FULL);
    // A pending byte is taken straight out of STOP so frames stay contiguous.
    assign tx_load   = tx_full &&
                       (tx_state == S_IDLE || (tx_state == S_STOP && tx_tick));
    assign tx_active = (tx_state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_full) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = tx_full ? S_START : S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
        end else begin
            if (wr_data && !tx_full) begin
                tx_hold <= bus.din;
                tx_full <= 1'b1;
            end
            if (tx_load) begin
                tx_full  <= 1'b0;
                tx_shift <= tx_hold;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state == S_IDLE) begin
                tx_cnt <= '0;
            end else if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_state == S_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    state_t rx_state, rx_next;
    logic [1:0] sync;
    logic rx_s, rx_prev, rx_fall, rx_half, rx_tick;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift, rx_buf;
    logic rx_ready, overrun, frame_err, rx_ie;
    logic done_ok, done_bad;

    assign rx_s    = sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    assign rx_half = (rx_cnt == HALF);
    assign rx_tick = (rx_cnt == FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        done_ok  = 1'b0;
        done_bad = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            done_ok  = rx_s;
            done_bad = ~rx_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_buf    <= '0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_ie     <= 1'b0;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= rx_s;
            if (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_START) rx_bit <= '0;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (done_ok) begin
                rx_buf   <= rx_shift;
                rx_ready <= 1'b1;
            end else if (rd_data) begin
                rx_ready <= 1'b0;
            end
            if (done_ok && rx_ready && !rd_data) overrun <= 1'b1;
            else if (rd_stat)                    overrun <= 1'b0;
            if (done_bad)     frame_err <= 1'b1;
            else if (rd_stat) frame_err <= 1'b0;
            if (wr_ctrl) rx_ie <= bus.din[0];
        end
    end

    always_comb begin
        case (bus.addr)
            2'd0:    bus.dout = rx_buf;
            2'd1:    bus.dout = {3'b0, tx_active, frame_err, overrun, tx_full, rx_ready};
            2'd2:    bus.dout = {7'b0, rx_ie};
            default: bus.dout = 8'hFF;
        endcase
    end

    assign bus.irq = rx_ie & rx_ready;
endmodule

// File: tb/tb_nes_uart.sv
// Directed bench for nes_uart: bus register access, TX frame timing and RX flags.
// TX bytes and RX bytes are checked against scoreboard queues.
module tb_nes_uart;
    localparam int CLK_HZ = 25000000;
    localparam int BAUD   = 115200;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int MID    = DIV / 2;

    logic clk, rst, rx, tx;
    nes_uart_if bus ();

    nes_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave),
        .rx    (rx),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.sel = 1; bus.we = 1; bus.addr = a; bus.din = d;
        @(negedge clk);
        bus.sel = 0; bus.we = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.sel = 1; bus.rd = 1; bus.addr = a;
        #1 d = bus.dout;
        @(negedge clk);
        bus.sel = 0; bus.rd = 0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        bus.sel = 0; bus.addr = a;
        #1 d = bus.dout;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 0;
        repeat (DIV) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1;
    endtask

    // TX line monitor: decodes frames at mid-bit and pops the scoreboard
    int cyc = 0, m_cnt = 0, m_last = 0, m_gap = 0;
    logic m_busy = 0, m_prev = 1;
    logic [7:0] m_byte;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_busy = 0;
            m_prev = 1;
        end else begin
            if (!m_busy) begin
                if (m_prev && !tx) begin
                    m_busy = 1; m_cnt = 0;
                    m_gap = cyc - m_last; m_last = cyc;
                end
            end else begin
                m_cnt++;
                if (m_cnt == MID) begin
                    check("tx_start_bit", tx, 0);
                end else if (m_cnt > MID && (m_cnt - MID) % DIV == 0) begin
                    int k;
                    k = (m_cnt - MID) / DIV;
                    if (k <= 8) m_byte[k-1] = tx;
                    else begin
                        check("tx_stop_bit", tx, 1);
                        tests++;
                        assert (tx_q.size() != 0) else begin
                            fails++;
                            $error("FAIL tx_unexpected observed=%0h expected=none", m_byte);
                        end
                        if (tx_q.size() != 0) check("tx_byte", m_byte, tx_q.pop_front());
                        m_busy = 0;
                    end
                end
            end
            m_prev = tx;
        end
    end

    initial begin
        logic [7:0] d, exp;
        int errs[10];
        int act_err;
        bus.sel = 0; bus.we = 0; bus.rd = 0; bus.addr = 0; bus.din = 0;
        rx = 1; rst = 1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_irq", bus.irq, 0);
        peek(0, d); check("rst_data", d, 8'h00);
        peek(1, d); check("rst_status", d, 8'h00);
        peek(2, d); check("rst_ctrl", d, 8'h00);
        peek(3, d); check("rst_reserved", d, 8'hFF);
        rst = 0;
        repeat (2) @(negedge clk);

        // exact bit timing of one frame
        tx_q.push_back(8'hA5);
        bus_write(0, 8'hA5);
        peek(1, d); check("a5_status_full", d, 8'h02);
        foreach (errs[s]) errs[s] = 0;
        act_err = 0;
        exp = 8'hA5;
        for (int i = 0; i < 10 * DIV; i++) begin
            int seg;
            logic e;
            @(negedge clk);
            seg = i / DIV;
            e = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : exp[seg-1];
            if (tx !== e) errs[seg]++;
            peek(1, d);
            if (d[4] !== 1'b1) act_err++;
        end
        for (int s = 0; s < 10; s++) check($sformatf("a5_seg%0d_errs", s), errs[s], 0);
        check("a5_active_errs", act_err, 0);
        @(negedge clk);
        peek(1, d); check("a5_active_clear", d, 8'h00);
        check("a5_tx_idle", tx, 1);
        repeat (20) @(negedge clk);

        // back-to-back frames, third write dropped
        tx_q.push_back(8'h01);
        bus_write(0, 8'h01);
        repeat (3) @(negedge clk);
        tx_q.push_back(8'h02);
        bus_write(0, 8'h02);
        peek(1, d); check("b2b_status", d, 8'h12);
        bus_write(0, 8'h03);
        peek(1, d); check("b2b_status_drop", d, 8'h12);
        repeat (2 * 10 * DIV + 400) @(negedge clk);
        check("b2b_gap", m_gap, 10 * DIV);
        check("b2b_q_empty", tx_q.size(), 0);

        // receive with interrupt
        bus_write(2, 8'h01);
        peek(2, d); check("ctrl_ie", d, 8'h01);
        rx_q.push_back(8'h3C);
        send_byte(8'h3C, 1);
        repeat (5) @(negedge clk);
        peek(1, d); check("rx_ready", d, 8'h01);
        check("rx_irq_on", bus.irq, 1);
        bus_read(0, d); check("rx_data", d, rx_q.pop_front());
        peek(1, d); check("rx_ready_clr", d, 8'h00);
        check("rx_irq_off", bus.irq, 0);

        // overrun
        rx_q.push_back(8'h11);
        send_byte(8'h11, 1);
        rx_q.push_back(8'h22);
        send_byte(8'h22, 1);
        repeat (5) @(negedge clk);
        bus_read(1, d); check("ovr_status", d, 8'h05);
        void'(rx_q.pop_front());
        bus_read(0, d); check("ovr_data", d, rx_q.pop_front());
        bus_read(1, d); check("ovr_cleared", d, 8'h00);

        // framing error keeps the buffered byte
        rx_q.push_back(8'h5A);
        send_byte(8'h5A, 1);
        send_byte(8'hA7, 0);
        repeat (5) @(negedge clk);
        bus_read(1, d); check("ferr_status", d, 8'h09);
        bus_read(0, d); check("ferr_data", d, rx_q.pop_front());
        peek(1, d); check("ferr_cleared", d, 8'h00);

        // short low pulse is rejected
        @(negedge clk);
        rx = 0;
        repeat (50) @(negedge clk);
        rx = 1;
        repeat (12 * DIV) @(negedge clk);
        peek(1, d); check("glitch_status", d, 8'h00);
        peek(0, d); check("glitch_data", d, 8'h5A);
        check("glitch_irq", bus.irq, 0);

        // reset during TX bit 4
        bus_write(0, 8'hC3);
        repeat (1 + 5 * DIV + 100) @(negedge clk);
        check("mid_tx_bit4", tx, 0);
        rst = 1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_irq", bus.irq, 0);
        peek(1, d); check("mid_rst_status", d, 8'h00);
        peek(0, d); check("mid_rst_data", d, 8'h00);
        peek(2, d); check("mid_rst_ctrl", d, 8'h00);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        tx_q.push_back(8'h96);
        bus_write(0, 8'h96);
        repeat (10 * DIV + 300) @(negedge clk);
        check("post_rst_q_empty", tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
